// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, column drive order and code width for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;
  localparam int CODE_W = 4;
  localparam logic [3:0] COL_ORDER [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  function automatic logic one_low(input logic [3:0] r);
    return $countones(~r) == 1;
  endfunction
  function automatic logic [1:0] low_idx(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every SCAN_TICK+1 clocks
module tick_gen #(
  parameter int PRESCALER_WIDTH = 16,
  parameter int SCAN_TICK       = 62500
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  logic [PRESCALER_WIDTH-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == PRESCALER_WIDTH'(SCAN_TICK);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix scanner with per-tick debounce of press and release
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 16,
  parameter int SCAN_TICK       = 62500,
  parameter int DEBOUNCE_SCANS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);
  logic [3:0] s1_q, sync_q, cnt_q, cnt_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic valid_q, valid_d, tick, hit, lat_low;
  state_e state_q, state_d;
  tick_gen #(.PRESCALER_WIDTH(PRESCALER_WIDTH), .SCAN_TICK(SCAN_TICK)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );
  assign hit     = one_low(sync_q) && low_idx(sync_q) == row_q;
  assign lat_low = !sync_q[row_q];
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (tick)
      case (state_q)
        SCAN:
          if (one_low(sync_q)) begin
            row_d   = low_idx(sync_q);
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else col_d = col_q + 2'd1;
        DEBOUNCE:
          if (hit) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DB_LAST) begin
              state_d = PRESSED;
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        PRESSED:
          if (!lat_low) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        RELEASE:
          if (lat_low) state_d = PRESSED;
          else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DB_LAST) begin
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end
          end
        default: state_d = SCAN;
      endcase
  end
  // rows are asynchronous to clk: two flops before any decision
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_q    <= 4'hF;
      sync_q  <= 4'hF;
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= row_in;
      sync_q  <= s1_q;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  assign col_out   = COL_ORDER[col_q];
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = state_q == PRESSED || state_q == RELEASE;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of the keypad scanner with a behavioural key matrix
module tb_keypad_scan;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row_in, col_out, key_code;
  logic key_valid, key_held;
  logic k1_en = 1'b0, k2_en = 1'b0;
  logic [1:0] k1_row = '0, k1_col = '0, k2_row = '0, k2_col = '0;
  int n_vec = 0, n_err = 0, valid_cnt = 0, v0, n;
  logic [3:0] prev;

  keypad_scan #(.PRESCALER_WIDTH(4), .SCAN_TICK(3), .DEBOUNCE_SCANS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    if (k1_en && !col_out[k1_col]) row_in[k1_row] = 1'b0;
    if (k2_en && !col_out[k2_col]) row_in[k2_row] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) valid_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] c);
    for (int i = 0; i < 40 && col_out !== c; i++) @(negedge clk);
    chk("wait_col", col_out, c);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && key_valid !== 1'b1; i++) @(negedge clk);
    chk("wait_valid", key_valid, 1);
  endtask

  task automatic wait_unheld();
    for (int i = 0; i < 60 && key_held !== 1'b0; i++) @(negedge clk);
    chk("wait_unheld", key_held, 0);
  endtask

  task automatic time_to_change(input logic [3:0] exp_next);
    prev = col_out;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (col_out !== prev) break;
    end
    chk("rot_period", n, 4);
    chk("rot_col", col_out, exp_next);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    reset = 1'b1;
    time_to_change(4'b1101);
    time_to_change(4'b1011);

    // press lifted for one tick while debouncing
    wait_col(4'b1110);
    k1_row = 2'd2; k1_col = 2'd1; k1_en = 1'b1;
    wait_col(4'b1101);
    v0 = valid_cnt;
    repeat (4) @(negedge clk);
    chk("deb_col_hold", col_out, 4'b1101);
    chk("deb_held", key_held, 0);
    k1_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("deb_abort_col", col_out, 4'b1011);
    chk("deb_abort_valid", valid_cnt, v0);
    repeat (20) @(negedge clk);
    chk("deb_abort_nov", valid_cnt, v0);

    // clean press of row 2 col 1
    k1_en = 1'b1;
    wait_valid();
    chk("p1_code", key_code, 4'h9);
    chk("p1_held", key_held, 1);
    @(negedge clk);
    chk("p1_pulse", key_valid, 0);
    v0 = valid_cnt;
    k2_row = 2'd0; k2_col = 2'd1; k2_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("second_key_nov", valid_cnt, v0);
    chk("second_key_held", key_held, 1);
    chk("second_key_col", col_out, 4'b1101);
    chk("second_key_code", key_code, 4'h9);
    k2_en = 1'b0;

    // single-tick release bounce
    k1_en = 1'b0;
    repeat (4) @(negedge clk);
    k1_en = 1'b1;
    repeat (16) @(negedge clk);
    chk("bounce_held", key_held, 1);
    chk("bounce_nov", valid_cnt, v0);
    chk("bounce_code", key_code, 4'h9);

    // real release
    k1_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("rel_early_held", key_held, 1);
    wait_unheld();
    chk("rel_col", col_out, 4'b1011);
    repeat (4) @(negedge clk);
    chk("rel_resume", col_out, 4'b0111);
    chk("rel_code_kept", key_code, 4'h9);

    // row 3 col 2
    k1_row = 2'd3; k1_col = 2'd2; k1_en = 1'b1;
    wait_valid();
    chk("p2_code", key_code, 4'hE);
    k1_en = 1'b0;
    wait_unheld();

    // two rows low in one column
    k1_row = 2'd0; k1_col = 2'd2; k1_en = 1'b1;
    k2_row = 2'd3; k2_col = 2'd2; k2_en = 1'b1;
    v0 = valid_cnt;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      prev = col_out;
      @(negedge clk);
      if (col_out !== prev) n++;
    end
    chk("multi_rot", n, 10);
    chk("multi_nov", valid_cnt, v0);
    chk("multi_held", key_held, 0);
    k1_en = 1'b0; k2_en = 1'b0;

    // reset while pressed
    k1_row = 2'd1; k1_col = 2'd0; k1_en = 1'b1;
    wait_valid();
    chk("p3_code", key_code, 4'h4);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_col", col_out, 4'b1110);
    chk("arst_held", key_held, 0);
    chk("arst_code", key_code, 0);
    chk("arst_valid", key_valid, 0);
    k1_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    time_to_change(4'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
